// File: rtl/adc_capture.sv
// Parallel ADC capture: generates the ADC sample clock and power/enable controls,
// and stores captured samples in a FIFO that the bus wrapper drains.
module adc_capture #(
  parameter int DATA_W      = 10,
  parameter int CLK_DIV     = 4,
  parameter int WAKE_CYCLES = 100,
  parameter int PIPE_DLY    = 2,
  parameter int FIFO_DEPTH  = 16,
  parameter int LVL_W       = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ctrl_start,
  input  logic              ctrl_stop,
  input  logic [15:0]       ctrl_count,
  input  logic              ctrl_fmt_twos,
  input  logic [0:DATA_W-1] adc_Data_pin,
  output logic              adc_Clk_pin,
  output logic              adc_PWRDN_pin,
  output logic              adc_OE_pin,
  input  logic              rd_en,
  output logic [0:DATA_W-1] rd_data,
  output logic              rd_valid,
  output logic              fifo_empty,
  output logic              fifo_full,
  output logic [LVL_W-1:0]  fifo_level,
  output logic              overflow,
  output logic              busy,
  output logic              done,
  output logic [1:0]        dbg_state
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int DIV_W  = $clog2(CLK_DIV);
  localparam int HALF   = CLK_DIV / 2;
  localparam int WAKE_W = $clog2(WAKE_CYCLES + 2);
  localparam int PIPE_W = $clog2(PIPE_DLY + 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAKE = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              state;
  logic [DIV_W-1:0]    div_cnt;
  logic [DIV_W-1:0]    div_nxt;
  logic [WAKE_W-1:0]   wake_cnt;
  logic [PIPE_W-1:0]   discard_cnt;
  logic [15:0]         sample_cnt;
  logic [15:0]         sample_nxt;
  logic [15:0]         count_lat;
  logic                fmt_lat;

  logic [0:DATA_W-1]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [0:DATA_W-1]   stored;

  logic strobe;
  logic take;
  logic rd_acc;
  logic wr_acc;
  logic drop;
  logic flush;
  logic last;

  assign dbg_state  = state;
  assign busy       = (state != S_IDLE);
  assign fifo_empty = (fifo_level == '0);
  assign fifo_full  = (fifo_level == LVL_W'(FIFO_DEPTH));

  assign div_nxt    = (div_cnt == DIV_W'(CLK_DIV - 1)) ? '0 : div_cnt + 1'b1;
  assign strobe     = (state == S_RUN) && (div_cnt == DIV_W'(CLK_DIV - 1));
  // A strobe that coincides with ctrl_stop is not stored or counted.
  assign take       = strobe && !ctrl_stop && (discard_cnt == '0);
  // Read handshake: rd_en is a request accepted only when the FIFO holds data;
  // an accepted request returns rd_data with a one-cycle rd_valid on the next edge.
  assign rd_acc     = rd_en && !fifo_empty;
  assign wr_acc     = take && (!fifo_full || rd_acc);
  assign drop       = take && !wr_acc;
  assign flush      = (state == S_IDLE) && ctrl_start && !ctrl_stop;
  assign sample_nxt = sample_cnt + 16'd1;
  assign last       = take && (count_lat != 16'd0) && (sample_nxt == count_lat);

  always_comb begin
    stored = adc_Data_pin;
    if (fmt_lat) stored[0] = ~adc_Data_pin[0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= S_IDLE;
      div_cnt       <= '0;
      wake_cnt      <= '0;
      discard_cnt   <= '0;
      sample_cnt    <= '0;
      count_lat     <= '0;
      fmt_lat       <= 1'b0;
      adc_Clk_pin   <= 1'b0;
      adc_PWRDN_pin <= 1'b1;
      adc_OE_pin    <= 1'b0;
      overflow      <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (flush) begin
            state         <= S_WAKE;
            div_cnt       <= '0;
            wake_cnt      <= '0;
            adc_Clk_pin   <= 1'b1;
            adc_PWRDN_pin <= 1'b0;
            adc_OE_pin    <= 1'b1;
            count_lat     <= ctrl_count;
            fmt_lat       <= ctrl_fmt_twos;
            sample_cnt    <= '0;
            overflow      <= 1'b0;
          end
        end
        S_WAKE: begin
          if (ctrl_stop) begin
            state         <= S_DONE;
            done          <= 1'b1;
            adc_Clk_pin   <= 1'b0;
            adc_PWRDN_pin <= 1'b1;
            adc_OE_pin    <= 1'b0;
          end else begin
            div_cnt     <= div_nxt;
            adc_Clk_pin <= (div_nxt < DIV_W'(HALF));
            if (wake_cnt == WAKE_W'(WAKE_CYCLES - 1)) begin
              state       <= S_RUN;
              discard_cnt <= PIPE_W'(PIPE_DLY);
            end else begin
              wake_cnt <= wake_cnt + 1'b1;
            end
          end
        end
        S_RUN: begin
          if (ctrl_stop) begin
            state         <= S_DONE;
            done          <= 1'b1;
            adc_Clk_pin   <= 1'b0;
            adc_PWRDN_pin <= 1'b1;
            adc_OE_pin    <= 1'b0;
          end else begin
            div_cnt     <= div_nxt;
            adc_Clk_pin <= (div_nxt < DIV_W'(HALF));
            if (strobe) begin
              if (discard_cnt != '0) begin
                discard_cnt <= discard_cnt - 1'b1;
              end else begin
                sample_cnt <= sample_nxt;
                if (drop) overflow <= 1'b1;
                if (last) begin
                  state         <= S_DONE;
                  done          <= 1'b1;
                  adc_Clk_pin   <= 1'b0;
                  adc_PWRDN_pin <= 1'b1;
                  adc_OE_pin    <= 1'b0;
                end
              end
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Storage has no reset; occupancy is tracked by pointers and level alone.
  always_ff @(posedge clk) begin
    if (rst && wr_acc) mem[wr_ptr] <= stored;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      if (flush) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fifo_level <= '0;
      end else begin
        if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
        if (rd_acc) begin
          rd_data  <= mem[rd_ptr];
          rd_ptr   <= rd_ptr + 1'b1;
          rd_valid <= 1'b1;
        end
        case ({wr_acc, rd_acc})
          2'b10:   fifo_level <= fifo_level + 1'b1;
          2'b01:   fifo_level <= fifo_level - 1'b1;
          default: fifo_level <= fifo_level;
        endcase
      end
    end
  end

endmodule
